// File: rtl/alu_req_resp_unit.sv
// rtl/alu_req_resp_unit.sv - ALU request/response unit with tagged output FIFO
// Requests are executed on accept and the full result entry is queued for the consumer.
module alu_req_resp_unit #(
    parameter int WIDTH = 4,
    parameter int TAG_W = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [7:0]       ops_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = WIDTH + TAG_W + 2;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [7:0]       ops_done_q, ops_done_d;

    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic [EW-1:0]    entry;
    logic [EW-1:0]    head;
    logic             full, empty, push, pop;

    always_comb begin
        ext       = '0;
        alu_res   = '0;
        alu_carry = 1'b0;
        case (req_op)
            3'b000: begin
                ext       = {1'b0, req_a} + {1'b0, req_b};
                alu_res   = ext[WIDTH-1:0];
                alu_carry = ext[WIDTH];
            end
            // Borrow falls out of the extended subtraction as the top bit.
            3'b001: begin
                ext       = {1'b0, req_a} - {1'b0, req_b};
                alu_res   = ext[WIDTH-1:0];
                alu_carry = ext[WIDTH];
            end
            3'b010: alu_res = req_a & req_b;
            3'b011: alu_res = req_a | req_b;
            3'b100: alu_res = req_a ^ req_b;
            3'b101: alu_res = ~req_a;
            3'b110: begin
                alu_res   = {req_a[WIDTH-2:0], 1'b0};
                alu_carry = req_a[WIDTH-1];
            end
            3'b111: begin
                alu_res   = {1'b0, req_a[WIDTH-1:1]};
                alu_carry = req_a[0];
            end
            default: ;
        endcase
    end

    assign entry     = {alu_carry, (alu_res == '0), req_tag, alu_res};
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign req_ready = !full || rsp_ready;
    assign rsp_valid = !empty;
    assign push      = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = entry;
        end
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ops_done_d = ops_done_q;
        if (pop && ops_done_q != 8'hff) begin
            ops_done_d = ops_done_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ops_done_q <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ops_done_q <= ops_done_d;
        end
    end

    // Storage is cleared on reset, so the head reads zero until the first push lands.
    assign head       = mem_q[rd_ptr_q];
    assign rsp_result = head[WIDTH-1:0];
    assign rsp_tag    = head[WIDTH +: TAG_W];
    assign rsp_zero   = head[WIDTH+TAG_W];
    assign rsp_carry  = head[WIDTH+TAG_W+1];
    assign ops_done   = ops_done_q;
endmodule

// File: tb/tb_alu_req_resp_unit.sv
// tb/tb_alu_req_resp_unit.sv - randomized and directed bench for alu_req_resp_unit
// Expected responses come from an arithmetic ALU model and a queue standing in for the FIFO.
module tb_alu_req_resp_unit;
    localparam int W     = 4;
    localparam int TW    = 2;
    localparam int DEPTH = 2;
    localparam int MOD   = 1 << W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready;
    logic [W-1:0]  req_a, req_b;
    logic [2:0]    req_op;
    logic [TW-1:0] req_tag;
    logic          rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_result;
    logic          rsp_carry, rsp_zero;
    logic [TW-1:0] rsp_tag;
    logic [7:0]    ops_done;

    typedef struct {
        int result;
        int carry;
        int zero;
        int tag;
    } rsp_t;

    rsp_t mq[$];
    int   m_ops;
    int   n_checks;
    int   n_pass;

    alu_req_resp_unit #(.WIDTH(W), .TAG_W(TW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .rsp_tag(rsp_tag), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic rsp_t alu_ref(input int a, input int b, input int op, input int tag);
        rsp_t r;
        r.carry = 0;
        case (op)
            0: begin r.result = (a + b) % MOD; r.carry = (a + b >= MOD); end
            1: begin r.result = (a - b + MOD) % MOD; r.carry = (a < b); end
            2: r.result = a & b;
            3: r.result = a | b;
            4: r.result = a ^ b;
            5: r.result = MOD - 1 - a;
            6: begin r.result = (a * 2) % MOD; r.carry = (a >= MOD / 2); end
            default: begin r.result = a / 2; r.carry = a % 2; end
        endcase
        r.zero = (r.result == 0);
        r.tag  = tag;
        return r;
    endfunction

    // Called just after a falling edge with inputs already set; returns at the next falling edge.
    task automatic tick();
        bit   do_push, do_pop;
        rsp_t e;
        #1;
        chk("rsp_valid", int'(rsp_valid), int'(mq.size() > 0));
        chk("req_ready", int'(req_ready), int'(mq.size() < DEPTH || rsp_ready));
        chk("ops_done", int'(ops_done), m_ops);
        if (mq.size() > 0) begin
            chk("rsp_result", int'(rsp_result), mq[0].result);
            chk("rsp_carry", int'(rsp_carry), mq[0].carry);
            chk("rsp_zero", int'(rsp_zero), mq[0].zero);
            chk("rsp_tag", int'(rsp_tag), mq[0].tag);
        end
        do_pop  = (mq.size() > 0) && rsp_ready;
        do_push = req_valid && (mq.size() < DEPTH || rsp_ready);
        e = alu_ref(int'(req_a), int'(req_b), int'(req_op), int'(req_tag));
        @(posedge clk);
        if (do_pop) begin
            void'(mq.pop_front());
            if (m_ops < 255) m_ops++;
        end
        if (do_push) mq.push_back(e);
        @(negedge clk);
    endtask

    task automatic drive(input int a, input int b, input int op, input int tag, input bit v, input bit rr);
        req_valid = v;
        req_a     = W'(a);
        req_b     = W'(b);
        req_op    = 3'(op);
        req_tag   = TW'(tag);
        rsp_ready = rr;
    endtask

    task automatic send_and_see(input int a, input int b, input int op,
                                input int er, input int ec, input int ez);
        drive(a, b, op, 0, 1'b1, 1'b0);
        tick();
        drive(0, 0, 0, 0, 1'b0, 1'b1);
        #1;
        chk("dir_result", int'(rsp_result), er);
        chk("dir_carry", int'(rsp_carry), ec);
        chk("dir_zero", int'(rsp_zero), ez);
        tick();
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++) tick();
        chk("drained", int'(rsp_valid), 0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_ops    = 0;
        rst_n    = 1'b0;
        drive(0, 0, 0, 0, 1'b0, 1'b0);
        #1;
        chk("rst_valid", int'(rsp_valid), 0);
        chk("rst_result", int'(rsp_result), 0);
        chk("rst_tag", int'(rsp_tag), 0);
        chk("rst_ops", int'(ops_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", int'(req_ready), 1);
        @(negedge clk);

        // A=3,B=1 through add/sub/and/or with the consumer always ready
        for (int op = 0; op < 4; op++) begin
            drive(3, 1, op, op, 1'b1, 1'b1);
            tick();
        end
        drain();
        chk("t1_ops", int'(ops_done), 4);

        send_and_see(15, 1, 0, 0, 1, 1);
        send_and_see(1, 3, 1, 14, 1, 0);
        send_and_see(9, 0, 6, 2, 1, 0);
        send_and_see(9, 0, 7, 4, 1, 0);
        send_and_see(9, 0, 5, 6, 0, 0);

        // Backpressure: third request stalls, then enters on the first pop edge
        drive(1, 1, 0, 1, 1'b1, 1'b0); tick();
        drive(2, 1, 0, 2, 1'b1, 1'b0); tick();
        drive(3, 1, 0, 3, 1'b1, 1'b0); tick();
        #1;
        chk("stall_ready", int'(req_ready), 0);
        chk("stall_head_tag", int'(rsp_tag), 1);
        drive(3, 1, 0, 3, 1'b1, 1'b1); tick();
        chk("full_swap_size", mq.size(), DEPTH);
        drive(0, 0, 0, 0, 1'b0, 1'b1);
        #1;
        chk("swap_head_tag", int'(rsp_tag), 2);
        drain();

        // Pop strobe on an empty FIFO has no effect
        drive(0, 0, 0, 0, 1'b0, 1'b1); tick();
        drive(0, 0, 0, 0, 1'b0, 1'b0); tick();
        chk("empty_pop_ops", int'(ops_done), m_ops);

        // Asynchronous reset with two entries held
        drive(5, 6, 2, 0, 1'b1, 1'b0); tick();
        drive(7, 1, 3, 1, 1'b1, 1'b0); tick();
        drive(0, 0, 0, 0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(rsp_valid), 0);
        chk("arst_ops", int'(ops_done), 0);
        chk("arst_result", int'(rsp_result), 0);
        mq.delete();
        m_ops = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send_and_see(2, 2, 4, 0, 0, 1);

        // Randomized traffic, long enough to push ops_done into saturation
        for (int i = 0; i < 700; i++) begin
            drive($urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1),
                  $urandom_range(0, 7), $urandom_range(0, (1 << TW) - 1),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            tick();
        end
        drain();
        chk("sat_ops", int'(ops_done), 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
